// File: rtl/perceptron_trainer_nd.sv
// Sequential N-input perceptron trainer: on-chip sample memory, one shared multiplier,
// saturating Q_M.Q_N arithmetic. Define PERCEPTRON_EARLY_STOP_EN to stop after an error-free epoch.
module perceptron_trainer_nd #(
  parameter int N_INPUTS = 2,
  parameter int DEPTH    = 4,
  parameter int EPOCHS   = 5,
  parameter int Q_M      = 15,
  parameter int Q_N      = 16,
  parameter logic signed [Q_M+Q_N:0] LEARNING_RATE = 1 << Q_N,
  parameter logic signed [Q_M+Q_N:0] BIAS          = 1 << Q_N,
  localparam int W  = 1 + Q_M + Q_N,
  localparam int AW = $clog2(DEPTH),
  localparam int IW = $clog2(N_INPUTS + 1),
  localparam int EW = $clog2(EPOCHS + 1),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  wr_en_i,
  input  logic [AW-1:0]         wr_addr_i,
  input  logic [N_INPUTS*W-1:0] wr_x_i,
  input  logic                  wr_target_i,
  input  logic                  wload_en_i,
  input  logic [IW-1:0]         wload_idx_i,
  input  logic [W-1:0]          wload_data_i,
  input  logic                  start_i,
  input  logic [IW-1:0]         wrd_idx_i,
  output logic [W-1:0]          wrd_data_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  converged_o,
  output logic [EW-1:0]         epoch_o,
  output logic [CW-1:0]         errors_o
);

  localparam int W2 = 2 * W;
  localparam int PW = 2 * W + 1;
  localparam logic [IW-1:0] LAST_W = IW'(N_INPUTS);
  localparam logic [IW-1:0] LAST_X = IW'(N_INPUTS - 1);
  localparam logic [AW-1:0] LAST_S = AW'(DEPTH - 1);
  localparam logic [EW-1:0] LAST_E = EW'(EPOCHS);
  localparam logic signed [PW-1:0] SAT_MAX = {{(PW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_MIN = {{(PW-W+1){1'b1}}, {(W-1){1'b0}}};

`ifdef PERCEPTRON_EARLY_STOP_EN
  localparam bit EARLY_STOP = 1'b1;
`else
  localparam bit EARLY_STOP = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_BIAS, S_MAC, S_DECIDE, S_UPDATE, S_NEXT, S_DONE} state_t;

  function automatic logic signed [W-1:0] sat_w(input logic signed [PW-1:0] v);
    if (v > SAT_MAX) return {1'b0, {(W-1){1'b1}}};
    if (v < SAT_MIN) return {1'b1, {(W-1){1'b0}}};
    return v[W-1:0];
  endfunction

  state_t                state_q, state_d;
  logic signed [W-1:0]   w_q [N_INPUTS+1];
  logic signed [W-1:0]   w_d [N_INPUTS+1];
  logic signed [W-1:0]   acc_q, acc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [AW-1:0]         samp_q, samp_d;
  logic [CW-1:0]         errcnt_q, errcnt_d;
  logic                  err_neg_q, err_neg_d;
  logic [EW-1:0]         epoch_q, epoch_d;
  logic [CW-1:0]         errors_q, errors_d;
  logic                  conv_q, conv_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [N_INPUTS*W-1:0] mem_x_q [DEPTH];
  logic [DEPTH-1:0]      mem_t_q;

  logic signed [W-1:0]   x_ext [N_INPUTS+1];
  logic signed [W-1:0]   op_a, op_b, base;
  logic                  neg;
  logic signed [W2-1:0]  prod, shifted;
  logic signed [PW-1:0]  delta;
  logic signed [W-1:0]   sum_sat;
  logic                  pred, tgt;
  logic [EW-1:0]         epoch_inc;

  // Sample memory has no reset; contents survive runs and resets.
  always_ff @(posedge clk_i) begin
    if (wr_en_i && !busy_q) begin
      mem_x_q[wr_addr_i] <= wr_x_i;
      mem_t_q[wr_addr_i] <= wr_target_i;
    end
  end

  always_comb begin
    for (int i = 0; i < N_INPUTS; i++) x_ext[i] = mem_x_q[samp_q][i*W +: W];
    x_ext[N_INPUTS] = BIAS;
  end

  // Shared multiplier: bias term, MAC terms and weight updates all pass through here.
  always_comb begin
    op_a = w_q[idx_q];
    op_b = x_ext[idx_q];
    base = acc_q;
    neg  = 1'b0;
    case (state_q)
      S_BIAS: begin
        op_a = w_q[N_INPUTS];
        op_b = BIAS;
        base = '0;
      end
      S_UPDATE: begin
        op_a = LEARNING_RATE;
        base = w_q[idx_q];
        neg  = err_neg_q;
      end
      default: ;
    endcase
    prod    = W2'(op_a) * W2'(op_b);
    shifted = prod >>> Q_N;
    delta   = PW'(shifted);
    if (neg) delta = -delta;
    sum_sat = sat_w(PW'(base) + delta);
  end

  assign pred      = ~acc_q[W-1];
  assign tgt       = mem_t_q[samp_q];
  assign epoch_inc = epoch_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    w_d       = w_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    samp_d    = samp_q;
    errcnt_d  = errcnt_q;
    err_neg_d = err_neg_q;
    epoch_d   = epoch_q;
    errors_d  = errors_q;
    conv_d    = conv_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    if (wload_en_i && !busy_q && (wload_idx_i <= LAST_W)) w_d[wload_idx_i] = wload_data_i;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        if (start_i) begin
          state_d  = S_BIAS;
          busy_d   = 1'b1;
          epoch_d  = '0;
          conv_d   = 1'b0;
          samp_d   = '0;
          errcnt_d = '0;
        end
      end
      S_BIAS: begin
        acc_d   = sum_sat;
        idx_d   = '0;
        state_d = S_MAC;
      end
      S_MAC: begin
        acc_d = sum_sat;
        if (idx_q == LAST_X) state_d = S_DECIDE;
        else                 idx_d   = idx_q + 1'b1;
      end
      S_DECIDE: begin
        if (tgt != pred) begin
          errcnt_d  = errcnt_q + 1'b1;
          err_neg_d = pred;
          idx_d     = '0;
          state_d   = S_UPDATE;
        end else begin
          state_d = S_NEXT;
        end
      end
      S_UPDATE: begin
        w_d[idx_q] = sum_sat;
        if (idx_q == LAST_W) state_d = S_NEXT;
        else                 idx_d   = idx_q + 1'b1;
      end
      S_NEXT: begin
        state_d = S_BIAS;
        if (samp_q == LAST_S) begin
          samp_d   = '0;
          epoch_d  = epoch_inc;
          errors_d = errcnt_q;
          conv_d   = (errcnt_q == '0);
          errcnt_d = '0;
          if ((epoch_inc == LAST_E) || (EARLY_STOP && (errcnt_q == '0))) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          samp_d = samp_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= S_IDLE;
      w_q       <= '{default: '0};
      acc_q     <= '0;
      idx_q     <= '0;
      samp_q    <= '0;
      errcnt_q  <= '0;
      err_neg_q <= 1'b0;
      epoch_q   <= '0;
      errors_q  <= '0;
      conv_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      w_q       <= w_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      samp_q    <= samp_d;
      errcnt_q  <= errcnt_d;
      err_neg_q <= err_neg_d;
      epoch_q   <= epoch_d;
      errors_q  <= errors_d;
      conv_q    <= conv_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign wrd_data_o  = (wrd_idx_i <= LAST_W) ? w_q[wrd_idx_i] : '0;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign converged_o = conv_q;
  assign epoch_o     = epoch_q;
  assign errors_o    = errors_q;

endmodule

// File: tb/tb_perceptron_trainer_nd.sv
// Bench for perceptron_trainer_nd: a plain-arithmetic perceptron model predicts per-epoch
// errors, epoch-close cycles and final weights; a compare process checks outputs every cycle.
module tb_perceptron_trainer_nd;
  localparam int N = 2;
  localparam int DEPTH = 4;
  localparam int EPOCHS = 10;
  localparam int W = 32;
  localparam longint ONE  = 64'sd65536;
  localparam longint WMAX = 64'sd2147483647;
  localparam longint WMIN = -64'sd2147483648;
`ifdef PERCEPTRON_EARLY_STOP_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic wr_en, wr_target, wload_en, start;
  logic [1:0] wr_addr, wload_idx, wrd_idx;
  logic [N*W-1:0] wr_x;
  logic [W-1:0] wload_data, wrd_data;
  logic busy, done, conv;
  logic [3:0] epoch;
  logic [2:0] errors;

  always #5 clk = ~clk;

  perceptron_trainer_nd #(.N_INPUTS(N), .DEPTH(DEPTH), .EPOCHS(EPOCHS)) dut (
    .clk_i(clk), .reset_ni(reset_n),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_x_i(wr_x), .wr_target_i(wr_target),
    .wload_en_i(wload_en), .wload_idx_i(wload_idx), .wload_data_i(wload_data),
    .start_i(start), .wrd_idx_i(wrd_idx), .wrd_data_o(wrd_data),
    .busy_o(busy), .done_o(done), .converged_o(conv), .epoch_o(epoch), .errors_o(errors)
  );

  longint shw [N+1];
  longint shx [DEPTH][N];
  bit     sht [DEPTH];
  int ep_end [EPOCHS];
  int ep_err [EPOCHS];
  int n_ep, t_end, prev_err;
  int n_tests = 0;
  int n_fail = 0;
  int runs_checked = 0;
  event run_started;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic longint sat(input longint v);
    if (v > WMAX) return WMAX;
    if (v < WMIN) return WMIN;
    return v;
  endfunction

  function automatic longint qmul(input longint a, input longint b);
    return (a * b) >>> 16;
  endfunction

  // Perceptron rule over the shadow memory; also records when each epoch closes.
  function automatic void model_run();
    longint acc, xj;
    int t, errs, y, err;
    t = 0;
    n_ep = 0;
    for (int e = 0; e < EPOCHS; e++) begin
      errs = 0;
      for (int s = 0; s < DEPTH; s++) begin
        acc = sat(qmul(shw[N], ONE));
        for (int i = 0; i < N; i++) acc = sat(acc + qmul(shw[i], shx[s][i]));
        y = (acc >= 0) ? 1 : 0;
        err = int'(sht[s]) - y;
        if (err != 0) begin
          errs++;
          for (int j = 0; j <= N; j++) begin
            xj = (j < N) ? shx[s][j] : ONE;
            shw[j] = sat(shw[j] + err * qmul(ONE, xj));
          end
          t += 2*N + 4;
        end else begin
          t += N + 3;
        end
      end
      ep_end[e] = t;
      ep_err[e] = errs;
      n_ep = e + 1;
      if (EARLY && errs == 0) break;
    end
    t_end = t;
  endfunction

  // Compare process: k counts edges after the start edge.
  initial begin
    int ne;
    forever begin
      @(run_started);
      for (int k = 0; k <= t_end + 1; k++) begin
        @(negedge clk);
        ne = 0;
        for (int e = 0; e < n_ep; e++) if (ep_end[e] <= k) ne = e + 1;
        check("busy_o", 64'(busy), 64'(k < t_end));
        check("done_o", 64'(done), 64'(k == t_end));
        check("epoch_o", 64'(epoch), 64'(ne));
        check("errors_o", 64'(errors), 64'((ne > 0) ? ep_err[ne-1] : prev_err));
        check("converged_o", 64'(conv), 64'((ne > 0) ? (ep_err[ne-1] == 0) : 0));
      end
      runs_checked++;
    end
  end

  task automatic write_sample(input int a, input longint x0, input longint x1, input bit t);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a[1:0]; wr_x = {x1[31:0], x0[31:0]}; wr_target = t;
    @(negedge clk);
    wr_en = 1'b0;
    shx[a][0] = x0; shx[a][1] = x1; sht[a] = t;
  endtask

  task automatic load_w(input int idx, input longint val);
    @(negedge clk);
    wload_en = 1'b1; wload_idx = idx[1:0]; wload_data = val[31:0]; wrd_idx = idx[1:0];
    @(posedge clk);
    #1 wload_en = 1'b0;
    check("wload_readback", 64'(wrd_data), 64'(val[31:0]));
    shw[idx] = val;
  endtask

  task automatic check_weights(input string name);
    longint v;
    for (int j = 0; j <= N; j++) begin
      @(negedge clk);
      wrd_idx = 2'(j);
      #1;
      v = shw[j];
      check(name, 64'(wrd_data), 64'(v[31:0]));
    end
  endtask

  task automatic run_check(input bit gate);
    int budget, want;
    model_run();
    want = runs_checked + 1;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    -> run_started;
    if (gate) begin
      repeat (3) @(negedge clk);
      start = 1'b1; wr_en = 1'b1; wr_addr = 2'd0; wr_x = {32'h0005_0000, 32'h0005_0000};
      wr_target = 1'b1; wload_en = 1'b1; wload_idx = 2'd0; wload_data = 32'h0012_3456;
      @(negedge clk);
      start = 1'b0; wr_en = 1'b0; wload_en = 1'b0;
    end
    budget = 0;
    while (runs_checked != want && budget < 2000) begin
      @(posedge clk);
      budget++;
    end
    n_tests++;
    if (runs_checked != want) begin
      n_fail++;
      $display("FAIL run_timeout: got no completion within %0d cycles, required one", budget);
    end
    prev_err = ep_err[n_ep-1];
    check_weights("final_weight");
  endtask

  task automatic zero_weights();
    for (int j = 0; j <= N; j++) load_w(j, 0);
  endtask

  initial begin
    start = 0; wr_en = 0; wload_en = 0; wr_addr = 0; wr_x = '0; wr_target = 0;
    wload_idx = 0; wload_data = 0; wrd_idx = 0;
    for (int j = 0; j <= N; j++) shw[j] = 0;
    prev_err = 0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 64'(busy), 0);
    check("reset_done", 64'(done), 0);
    check("reset_epoch", 64'(epoch), 0);
    check("reset_errors", 64'(errors), 0);
    check("reset_conv", 64'(conv), 0);
    check_weights("reset_weight");
    @(negedge clk) reset_n = 1'b1;

    // AND dataset
    write_sample(0, 0, 0, 0);
    write_sample(1, 0, ONE, 0);
    write_sample(2, ONE, 0, 0);
    write_sample(3, ONE, ONE, 1);
    load_w(0, 64'h12345);
    zero_weights();
    run_check(0);
    check("and_epoch", 64'(epoch), EARLY ? 64'd6 : 64'd10);
    check("and_errors", 64'(errors), 0);
    check("and_conv", 64'(conv), 1);
    check_weights("and_model_weight");
    wrd_idx = 2'd0; #1 check("and_w0", 64'(wrd_data), 64'h0002_0000);
    wrd_idx = 2'd1; #1 check("and_w1", 64'(wrd_data), 64'h0001_0000);
    wrd_idx = 2'd2; #1 check("and_wb", 64'(wrd_data), 64'hFFFD_0000);

    // Continue from converged weights
    run_check(0);
    check("cont_epoch", 64'(epoch), EARLY ? 64'd1 : 64'd10);
    check("cont_conv", 64'(conv), 1);

    // Reset in the middle of MAC
    zero_weights();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #3 reset_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 0);
    check("abort_done", 64'(done), 0);
    check("abort_epoch", 64'(epoch), 0);
    check("abort_errors", 64'(errors), 0);
    check("abort_conv", 64'(conv), 0);
    @(negedge clk) reset_n = 1'b1;
    for (int j = 0; j <= N; j++) shw[j] = 0;
    prev_err = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("abort_no_done", 64'(done), 0);
    end
    check_weights("abort_weight");
    run_check(0);
    wrd_idx = 2'd2; #1 check("rerun_wb", 64'(wrd_data), 64'hFFFD_0000);

    // Busy gating: mid-run start/write/load must be dropped
    zero_weights();
    run_check(1);
    wrd_idx = 2'd0; #1 check("gate_w0", 64'(wrd_data), 64'h0002_0000);
    check("gate_conv", 64'(conv), 1);

    // XOR dataset never converges
    write_sample(0, 0, 0, 0);
    write_sample(1, 0, ONE, 1);
    write_sample(2, ONE, 0, 1);
    write_sample(3, ONE, ONE, 0);
    zero_weights();
    run_check(0);
    check("xor_epoch", 64'(epoch), 64'd10);
    check("xor_conv", 64'(conv), 0);
    check("xor_errors_nonzero", 64'(errors != 0), 1);

    // Saturation: acc driven to the negative rail, w0 must clamp rather than wrap
    for (int s = 0; s < DEPTH; s++) write_sample(s, 100*ONE, -100*ONE, 1);
    load_w(0, 64'sh7FFF_0000);
    load_w(1, 64'sh7FFF_0000);
    load_w(2, -64'sh7FFF_0000);
    run_check(0);
    wrd_idx = 2'd0; #1 check("sat_w0", 64'(wrd_data), 64'h7FFF_FFFF);
    check("sat_conv", 64'(conv), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
